// File: rtl/car_alarm_controller_pkg.sv
// -----------------------------------------------------------------------------
// car_alarm_controller_pkg
// Shared definitions for the car alarm controller:
//   - state_e       : FSM state encoding, also driven out as StateCode
//   - CNT_W         : width of the tick down-counter
//   - DEF_*_TICKS   : default dwell lengths in TickPulse periods
//   - is_armed_state: states in which the armed LED is steadily lit
// -----------------------------------------------------------------------------
package car_alarm_controller_pkg;

    localparam int CNT_W = 5;

    localparam int DEF_EXIT_TICKS  = 8;
    localparam int DEF_ENTRY_TICKS = 4;
    localparam int DEF_SIREN_TICKS = 16;

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_SIREN       = 3'd4
    } state_e;

    function automatic logic is_armed_state(input state_e s);
        return (s == ST_ARMED) || (s == ST_ENTRY_DELAY) || (s == ST_SIREN);
    endfunction

endpackage

// File: rtl/car_alarm_controller_if.sv
// -----------------------------------------------------------------------------
// car_alarm_controller_if
// Sensor/key-fob inputs and alarm outputs of the car alarm controller.
//   master : the vehicle side (drives sensors, fob requests, timebase strobe)
//   slave  : the alarm controller (drives chime, siren, LED, state code)
// -----------------------------------------------------------------------------
interface car_alarm_controller_if;

    logic       CarLightsOnSign;
    logic       OpenDoorSign;
    logic       IgnitionSignalOn;
    logic       ArmRequest;
    logic       DisarmRequest;
    logic       TickPulse;

    logic       CarAlarmSignal;
    logic       SirenOn;
    logic       ArmedIndicator;
    logic [2:0] StateCode;

    modport master (
        output CarLightsOnSign, OpenDoorSign, IgnitionSignalOn,
               ArmRequest, DisarmRequest, TickPulse,
        input  CarAlarmSignal, SirenOn, ArmedIndicator, StateCode
    );

    modport slave (
        input  CarLightsOnSign, OpenDoorSign, IgnitionSignalOn,
               ArmRequest, DisarmRequest, TickPulse,
        output CarAlarmSignal, SirenOn, ArmedIndicator, StateCode
    );

endinterface

// File: rtl/car_alarm_controller_tick_down_counter.sv
// -----------------------------------------------------------------------------
// tick_down_counter
// Dwell timer for the timed alarm states.
//   clk, reset : system clock, synchronous active-high reset
//   load       : load load_val this clock (wins over tick)
//   load_val   : dwell length in ticks (0 parks the counter)
//   tick       : one-cycle timebase strobe
//   expire     : tick seen while the count is 1, i.e. the N-th tick after load
// A parked counter (0) ignores ticks, so stray strobes never wrap it.
// -----------------------------------------------------------------------------
module tick_down_counter
    import car_alarm_controller_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);

    logic [W-1:0] count_q, count_d;

    // Expiry looks only at the current count, not at load, so the FSM may
    // use it to decide a reload without forming a combinational loop.
    assign expire = tick && (count_q == W'(1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/car_alarm_controller.sv
// -----------------------------------------------------------------------------
// car_alarm_controller
// Five-state car alarm: DISARMED -> EXIT_DELAY -> ARMED -> ENTRY_DELAY -> SIREN.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : sensors, key-fob requests and TickPulse in; CarAlarmSignal
//                (lights-on chime), SirenOn, ArmedIndicator, StateCode out
// All outputs are registered and computed from the next state, so they show
// the state entered on the same clock edge.
// -----------------------------------------------------------------------------
module car_alarm_controller
    import car_alarm_controller_pkg::*;
#(
    parameter int EXIT_TICKS  = DEF_EXIT_TICKS,
    parameter int ENTRY_TICKS = DEF_ENTRY_TICKS,
    parameter int SIREN_TICKS = DEF_SIREN_TICKS
) (
    input  logic                  clk,
    input  logic                  reset,
    car_alarm_controller_if.slave bus
);

    state_e             state_q, state_d;
    logic               siren_q, siren_d;
    logic               armed_q, armed_d;
    logic               chime_q, chime_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_expire;

    tick_down_counter #(.W(CNT_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tick     (bus.TickPulse),
        .expire   (cnt_expire)
    );

    // Next-state and counter control. Leaving for an untimed state loads 0
    // so the counter is parked and later ticks cannot expire it.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        if (bus.DisarmRequest) begin
            state_d  = ST_DISARMED;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_DISARMED: begin
                    if (bus.ArmRequest && !bus.OpenDoorSign && !bus.IgnitionSignalOn) begin
                        state_d      = ST_EXIT_DELAY;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(EXIT_TICKS);
                    end
                end
                ST_EXIT_DELAY: begin
                    if (bus.IgnitionSignalOn) begin
                        state_d  = ST_DISARMED;
                        cnt_load = 1'b1;
                    end else if (bus.OpenDoorSign) begin
                        // Door reopened: restart the full exit delay.
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(EXIT_TICKS);
                    end else if (cnt_expire) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (bus.IgnitionSignalOn) begin
                        state_d      = ST_SIREN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(SIREN_TICKS);
                    end else if (bus.OpenDoorSign) begin
                        state_d      = ST_ENTRY_DELAY;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(ENTRY_TICKS);
                    end
                end
                ST_ENTRY_DELAY: begin
                    if (cnt_expire) begin
                        state_d      = ST_SIREN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(SIREN_TICKS);
                    end
                end
                ST_SIREN: begin
                    if (cnt_expire) begin
                        if (!bus.OpenDoorSign && !bus.IgnitionSignalOn) begin
                            state_d = ST_ARMED;
                        end else begin
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(SIREN_TICKS);
                        end
                    end
                end
                default: begin
                    // Unused codes 5..7 recover to DISARMED.
                    state_d  = ST_DISARMED;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        siren_d = (state_d == ST_SIREN);
        chime_d = (state_d == ST_DISARMED) && bus.CarLightsOnSign &&
                  bus.OpenDoorSign && !bus.IgnitionSignalOn;
        armed_d = is_armed_state(state_d);
        if (state_d == ST_EXIT_DELAY) begin
            // Blink: lit on entry, then toggle on every tick while waiting.
            if (state_q != ST_EXIT_DELAY) begin
                armed_d = 1'b1;
            end else if (bus.TickPulse) begin
                armed_d = !armed_q;
            end else begin
                armed_d = armed_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DISARMED;
            siren_q <= 1'b0;
            armed_q <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            state_q <= state_d;
            siren_q <= siren_d;
            armed_q <= armed_d;
            chime_q <= chime_d;
        end
    end

    assign bus.StateCode      = state_q;
    assign bus.SirenOn        = siren_q;
    assign bus.ArmedIndicator = armed_q;
    assign bus.CarAlarmSignal = chime_q;

endmodule

// File: tb/tb_car_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_car_alarm_controller
// Directed bench for car_alarm_controller with default tick parameters
// (exit 8, entry 4, siren 16). Inputs change 1 time unit after a rising edge,
// outputs are sampled 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_car_alarm_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    car_alarm_controller_if bus ();

    car_alarm_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // in  = {lights, door, ignition, arm, disarm, tick}
    // out = {siren, armed_led, chime}
    typedef struct packed {
        logic [5:0] in;
        logic [2:0] st;
        logic [2:0] out;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [2:0] st,
                              input logic siren, input logic armed, input logic chime);
        check({name, "_state"}, 32'(bus.StateCode), 32'(st));
        check({name, "_siren"}, 32'(bus.SirenOn), 32'(siren));
        check({name, "_armed"}, 32'(bus.ArmedIndicator), 32'(armed));
        check({name, "_chime"}, 32'(bus.CarAlarmSignal), 32'(chime));
    endtask

    task automatic drive(input logic [5:0] in);
        bus.CarLightsOnSign  = in[5];
        bus.OpenDoorSign     = in[4];
        bus.IgnitionSignalOn = in[3];
        bus.ArmRequest       = in[2];
        bus.DisarmRequest    = in[1];
        bus.TickPulse        = in[0];
    endtask

    task automatic apply(input logic [5:0] in);
        drive(in);
        @(posedge clk);
        #1;
    endtask

    // From DISARMED with door closed: arm, then run out the exit delay.
    task automatic arm_fully(input string name);
        apply(6'b000100);
        for (int k = 0; k < 8; k++) apply(6'b000001);
        apply(6'b000000);
        expect_out(name, 3'd2, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        vecs[0]  = {6'b000000, 3'd0, 3'b000};
        vecs[1]  = {6'b110000, 3'd0, 3'b001};  // lights + door -> chime
        vecs[2]  = {6'b110100, 3'd0, 3'b001};  // arm with door open ignored
        vecs[3]  = {6'b100000, 3'd0, 3'b000};  // door closed -> chime off
        vecs[4]  = {6'b001100, 3'd0, 3'b000};  // arm with ignition ignored
        vecs[5]  = {6'b000001, 3'd0, 3'b000};  // tick in DISARMED
        vecs[6]  = {6'b000110, 3'd0, 3'b000};  // arm + disarm -> disarm wins
        vecs[7]  = {6'b000100, 3'd1, 3'b010};  // arm -> EXIT_DELAY, LED on
        vecs[8]  = {6'b000100, 3'd1, 3'b010};  // re-arm ignored, no tick
        vecs[9]  = {6'b000001, 3'd1, 3'b000};  // tick 1
        vecs[10] = {6'b000001, 3'd1, 3'b010};  // tick 2
        vecs[11] = {6'b000001, 3'd1, 3'b000};  // tick 3
        vecs[12] = {6'b000001, 3'd1, 3'b010};  // tick 4
        vecs[13] = {6'b000001, 3'd1, 3'b000};  // tick 5
        vecs[14] = {6'b000001, 3'd1, 3'b010};  // tick 6
        vecs[15] = {6'b000001, 3'd1, 3'b000};  // tick 7
        vecs[16] = {6'b000001, 3'd2, 3'b010};  // tick 8 -> ARMED
        vecs[17] = {6'b000001, 3'd2, 3'b010};  // tick in ARMED
        vecs[18] = {6'b110010, 3'd0, 3'b001};  // disarm beats door; chime
        vecs[19] = {6'b000000, 3'd0, 3'b000};

        // Reset
        drive(6'b000000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Table-driven vectors
        for (int v = 0; v < NVEC; v++) begin
            apply(vecs[v].in);
            expect_out($sformatf("vec%0d", v), vecs[v].st,
                       vecs[v].out[2], vecs[v].out[1], vecs[v].out[0]);
        end

        // Door opens while armed -> entry delay -> siren -> back to ARMED
        arm_fully("A_arm");
        apply(6'b010000);
        expect_out("A_entry", 3'd3, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            apply(6'b000001);
            expect_out($sformatf("A_etick%0d", k), 3'd3, 1'b0, 1'b1, 1'b0);
            apply(6'b000000);
            expect_out($sformatf("A_eidle%0d", k), 3'd3, 1'b0, 1'b1, 1'b0);
        end
        apply(6'b000001);
        expect_out("A_siren", 3'd4, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            apply(6'b000001);
            check($sformatf("A_stick%0d_state", k), 32'(bus.StateCode), 32'd4);
            check($sformatf("A_stick%0d_siren", k), 32'(bus.SirenOn), 32'd1);
        end
        apply(6'b000001);
        expect_out("A_rearm", 3'd2, 1'b0, 1'b1, 1'b0);

        // Ignition while armed -> immediate siren, reload while ignition stays on
        apply(6'b001000);
        expect_out("B_siren", 3'd4, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) apply(6'b001001);
        expect_out("B_reload", 3'd4, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 15; k++) apply(6'b000001);
        expect_out("B_tick15", 3'd4, 1'b1, 1'b1, 1'b0);
        apply(6'b000001);
        expect_out("B_rearm", 3'd2, 1'b0, 1'b1, 1'b0);

        // Disarm coincides with the final entry-delay tick
        apply(6'b010000);
        expect_out("C_entry", 3'd3, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) apply(6'b000001);
        expect_out("C_last", 3'd3, 1'b0, 1'b1, 1'b0);
        apply(6'b000011);
        expect_out("C_disarm", 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            apply(6'b000001);
            expect_out($sformatf("C_after%0d", k), 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // Exit delay: door reopening restarts it, ignition aborts it
        apply(6'b000100);
        expect_out("D_exit", 3'd1, 1'b0, 1'b1, 1'b0);
        apply(6'b000001);
        expect_out("D_tick1", 3'd1, 1'b0, 1'b0, 1'b0);
        apply(6'b010000);
        expect_out("D_reload", 3'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            apply(6'b000001);
            expect_out($sformatf("D_rtick%0d", k), 3'd1, 1'b0, 1'((k % 2) == 1), 1'b0);
        end
        apply(6'b000001);
        expect_out("D_armed", 3'd2, 1'b0, 1'b1, 1'b0);
        apply(6'b000010);
        apply(6'b000100);
        expect_out("D_exit2", 3'd1, 1'b0, 1'b1, 1'b0);
        apply(6'b001000);
        expect_out("D_ign_abort", 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset during SIREN; no delay resumes afterwards
        arm_fully("E_arm");
        apply(6'b001000);
        for (int k = 0; k < 3; k++) apply(6'b000001);
        expect_out("E_siren", 3'd4, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        apply(6'b011001);
        reset = 1'b0;
        expect_out("E_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) apply(6'b000001);
        expect_out("E_after", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/car_alarm_controller.md
CAR_ALARM_CONTROLLER -- requirements
Module: car_alarm_controller

Interface
REQ-001 Parameter EXIT_TICKS, default 8: exit-delay length in TickPulse periods (legal 1..31).
REQ-002 Parameter ENTRY_TICKS, default 4: entry-delay length in TickPulse periods (legal 1..31).
REQ-003 Parameter SIREN_TICKS, default 16: siren burst length in TickPulse periods (legal 1..31).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 CarLightsOnSign  input  1  headlights on.
REQ-007 OpenDoorSign  input  1  any door open.
REQ-008 IgnitionSignalOn  input  1  ignition on.
REQ-009 ArmRequest  input  1  one-cycle arm command from key fob.
REQ-010 DisarmRequest  input  1  one-cycle disarm command from key fob.
REQ-011 TickPulse  input  1  one-cycle timebase strobe; all delays count this strobe only.
REQ-012 CarAlarmSignal  output  1  lights-left-on reminder chime.
REQ-013 SirenOn  output  1  siren drive.
REQ-014 ArmedIndicator  output  1  armed LED.
REQ-015 StateCode  output  3  current FSM state encoding.

Function
REQ-016 FSM states and StateCode values: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, SIREN=4; codes 5..7 are unreachable and, if ever decoded, return to DISARMED on the next clock.
REQ-017 A 5-bit down-counter is loaded with N on entry to a timed state; on each TickPulse it decrements, except that TickPulse with counter==1 ends the state, giving exactly N TickPulses of dwell.
REQ-018 DisarmRequest in any state moves to DISARMED on the next clock and has priority over every other event, including a simultaneous ArmRequest, timer expiry or sensor event.
REQ-019 DISARMED: ArmRequest with OpenDoorSign=0 and IgnitionSignalOn=0 moves to EXIT_DELAY and loads EXIT_TICKS; otherwise ArmRequest is ignored.
REQ-020 EXIT_DELAY: OpenDoorSign=1 reloads EXIT_TICKS and holds the state; IgnitionSignalOn=1 returns to DISARMED; expiry moves to ARMED.
REQ-021 ARMED: IgnitionSignalOn=1 moves directly to SIREN and loads SIREN_TICKS; otherwise OpenDoorSign=1 moves to ENTRY_DELAY and loads ENTRY_TICKS; ignition has priority if both are set.
REQ-022 ENTRY_DELAY: sensors are ignored; expiry moves to SIREN and loads SIREN_TICKS.
REQ-023 SIREN: expiry moves to ARMED if OpenDoorSign=0 and IgnitionSignalOn=0; otherwise it reloads SIREN_TICKS and stays in SIREN.
REQ-024 ArmRequest outside DISARMED is ignored; TickPulse outside timed states has no effect.
REQ-025 All outputs are registered and reflect the state entered on the same clock edge.
REQ-026 SirenOn=1 only in SIREN.
REQ-027 ArmedIndicator=1 in ARMED, ENTRY_DELAY and SIREN.
REQ-028 In EXIT_DELAY, ArmedIndicator toggles on each TickPulse, starting at 1 on entry.
REQ-029 CarAlarmSignal=1 in DISARMED when CarLightsOnSign=1, OpenDoorSign=1 and IgnitionSignalOn=0, with one clock of latency; it is 0 in every other state.

Reset
REQ-030 With reset=1 at a rising clk, the state becomes DISARMED, the counter becomes 0, and CarAlarmSignal, SirenOn, ArmedIndicator and StateCode all become 0.
REQ-031 Reset has priority over every input, including mid-delay and during SIREN; no delay resumes after reset.

Structure
REQ-032 A shared package/include holds the state encodings, the 5-bit counter width and the default tick constants.
REQ-033 The counter is a sub-module, tick_down_counter, with load, load value, TickPulse input and an expire output; the FSM and output registers stay in car_alarm_controller.

Verification
REQ-034 Reset, then ArmRequest with door closed and ignition off, then 8 TickPulses -> StateCode 1 then 2 after the 8th pulse; ArmedIndicator toggles 7 times, then holds 1.
REQ-035 In ARMED, OpenDoorSign=1 and no disarm, then 4 TickPulses -> StateCode 3, then 4; SirenOn=1 for 16 TickPulses; door closed at expiry -> StateCode 2 and SirenOn=0.
REQ-036 In ARMED, IgnitionSignalOn=1 -> StateCode 4 next clock; ignition still on at expiry -> stays in 4 for another 16 TickPulses.
REQ-037 In ENTRY_DELAY, DisarmRequest and TickPulse in the same cycle with counter==1 -> StateCode 0; SirenOn never asserts.
REQ-038 In DISARMED, lights=1, door=1, ignition=0 -> CarAlarmSignal=1 one clock later; ArmRequest with door open -> ignored, StateCode stays 0.
REQ-039 reset=1 for one clock during SIREN -> all outputs 0 next clock; subsequent TickPulses leave StateCode at 0.
